pwm_duty_slew: RTL and testbench

//   Slew-rate limiter between the SPI register file and the PWM peripheral.

---
 rtl/pwm_duty_slew.sv | 115 +++++++++++
 tb/tb_pwm_duty_slew.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_slew.sv
// Slew-rate limiter between the SPI duty register and the PWM: ramps duty_out
// towards target_duty in bounded steps, updating only on PWM period boundaries.
module pwm_duty_slew #(
    parameter int DIV_W  = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        target_duty,
    input  logic              ramp_en,
    input  logic [STEP_W-1:0] step_size,
    input  logic [DIV_W-1:0]  ramp_div,
    input  logic              period_start,
    output logic [7:0]        duty_out,
    output logic              at_target,
    output logic              ramping
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;

    logic [7:0]       duty_q, duty_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_pend_q, tick_pend_d;
    logic [1:0]       state_q, state_d;
    logic             at_target_q, at_target_d;
    logic             ramping_q, ramping_d;
    logic             tick, commit, load;
    logic [8:0]       step9;

    // Clamp an upward step so it lands exactly on the target instead of overshooting.
    function automatic logic [7:0] step_up(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic [8:0] s);
        logic [8:0] gap;
        gap = {1'b0, tgt} - {1'b0, cur};
        return (gap <= s) ? tgt : 8'({1'b0, cur} + s);
    endfunction

    function automatic logic [7:0] step_down(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [8:0] s);
        logic [8:0] gap;
        gap = {1'b0, cur} - {1'b0, tgt};
        return (gap <= s) ? tgt : 8'({1'b0, cur} - s);
    endfunction

    always_comb begin
        step9  = (step_size == '0) ? 9'd1 : 9'(step_size);
        tick   = (state_q != S_IDLE) && (div_cnt_q >= ramp_div);
        load   = period_start && !ramp_en;
        commit = period_start && ramp_en && (tick || tick_pend_q);

        duty_d = duty_q;
        if (load) begin
            duty_d = target_duty;
        end else if (commit) begin
            if (target_duty > duty_q) begin
                duty_d = step_up(duty_q, target_duty, step9);
            end else if (target_duty < duty_q) begin
                duty_d = step_down(duty_q, target_duty, step9);
            end
        end

        // Direction follows the live target every cycle, so reversals need no extra state.
        if (target_duty > duty_d) begin
            state_d = S_UP;
        end else if (target_duty < duty_d) begin
            state_d = S_DOWN;
        end else begin
            state_d = S_IDLE;
        end

        if (state_d == S_IDLE || state_q == S_IDLE) begin
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if (state_d == S_IDLE || commit) begin
            tick_pend_d = 1'b0;
        end else if (tick) begin
            tick_pend_d = 1'b1;
        end else begin
            tick_pend_d = tick_pend_q;
        end

        at_target_d = (duty_d == target_duty);
        ramping_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q      <= 8'd0;
            div_cnt_q   <= '0;
            tick_pend_q <= 1'b0;
            state_q     <= S_IDLE;
            at_target_q <= 1'b1;
            ramping_q   <= 1'b0;
        end else begin
            duty_q      <= duty_d;
            div_cnt_q   <= div_cnt_d;
            tick_pend_q <= tick_pend_d;
            state_q     <= state_d;
            at_target_q <= at_target_d;
            ramping_q   <= ramping_d;
        end
    end

    assign duty_out  = duty_q;
    assign at_target = at_target_q;
    assign ramping   = ramping_q;

endmodule

// File: tb/tb_pwm_duty_slew.sv
// Bench for pwm_duty_slew: a vector table, directed boundary sequences, and
// randomized traffic compared against an arithmetic reference model.
module tb_pwm_duty_slew;

    logic        clk;
    logic        rst_n;
    logic [7:0]  target_duty;
    logic        ramp_en;
    logic [3:0]  step_size;
    logic [15:0] ramp_div;
    logic        period_start;
    logic [7:0]  duty_out;
    logic        at_target;
    logic        ramping;

    int checks = 0;
    int errors = 0;

    pwm_duty_slew #(.DIV_W(16), .STEP_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .target_duty  (target_duty),
        .ramp_en      (ramp_en),
        .step_size    (step_size),
        .ramp_div     (ramp_div),
        .period_start (period_start),
        .duty_out     (duty_out),
        .at_target    (at_target),
        .ramping      (ramping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  target;
        logic        en;
        logic [3:0]  step;
        logic [15:0] div;
        logic        ps;
        int          exp_duty;
        logic        exp_at;
        logic        exp_ramp;
    } vec_t;

    vec_t vecs[16];

    // Reference model: duty value, whether a ramp is active, whether a step is
    // owed, and how many cycles the current ramp has been active.
    int m_duty;
    bit m_active;
    bit m_pend;
    int m_n;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_duty = 0; m_active = 0; m_pend = 0; m_n = 0;
    endtask

    task automatic model_step();
        int s, div, tgt;
        bit tk, cm, nact;
        s   = (step_size == 0) ? 1 : int'(step_size);
        div = int'(ramp_div);
        tgt = int'(target_duty);
        tk  = m_active && ((m_n % (div + 1)) == div);
        cm  = period_start && ramp_en && (tk || m_pend);
        if (period_start && !ramp_en) begin
            m_duty = tgt;
        end else if (cm) begin
            if (tgt > m_duty) m_duty = (tgt - m_duty <= s) ? tgt : m_duty + s;
            else if (tgt < m_duty) m_duty = (m_duty - tgt <= s) ? tgt : m_duty - s;
        end
        nact = (m_duty != tgt);
        if (!nact) begin
            m_pend = 0;
            m_n    = 0;
        end else begin
            if (cm) m_pend = 0;
            else if (tk) m_pend = 1;
            m_n = m_active ? m_n + 1 : 0;
        end
        m_active = nact;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        period_start = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic boundary(input int gap);
        period_start = 1'b0;
        for (int i = 0; i < gap - 1; i++) cyc();
        period_start = 1'b1;
        cyc();
        period_start = 1'b0;
    endtask

    task automatic preset(input int v);
        ramp_en = 1'b0;
        target_duty = 8'(v);
        period_start = 1'b1;
        cyc();
        period_start = 1'b0;
        ramp_en = 1'b1;
        cyc();
    endtask

    initial begin
        int exp_tab[16];
        int e;
        rst_n = 1'b0;
        target_duty = 8'h80;
        ramp_en = 1'b1;
        step_size = 4'd3;
        ramp_div = 16'd0;
        period_start = 1'b0;
        model_reset();

        // Reset state with a non-zero target pending
        cyc();
        cyc();
        chk("reset_duty", int'(duty_out), 0);
        chk("reset_at_target", int'(at_target), 1);
        chk("reset_ramping", int'(ramping), 0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("post_reset_ramping", int'(ramping), 1);
        chk("post_reset_at_target", int'(at_target), 0);

        // Ramp-up vector table: step 3, tick every cycle, boundary every 4 cycles
        target_duty = 8'd0;
        do_reset();
        exp_tab = '{0, 0, 3, 3, 3, 3, 6, 6, 6, 6, 9, 9, 9, 9, 10, 10};
        for (int i = 0; i < 16; i++) begin
            vecs[i].target   = 8'd10;
            vecs[i].en       = 1'b1;
            vecs[i].step     = 4'd3;
            vecs[i].div      = 16'd0;
            vecs[i].ps       = ((i % 4) == 2);
            vecs[i].exp_duty = exp_tab[i];
            vecs[i].exp_at   = (i >= 14);
            vecs[i].exp_ramp = (i < 14);
        end
        for (int i = 0; i < 16; i++) begin
            target_duty  = vecs[i].target;
            ramp_en      = vecs[i].en;
            step_size    = vecs[i].step;
            ramp_div     = vecs[i].div;
            period_start = vecs[i].ps;
            cyc();
            chk($sformatf("vec%0d_duty", i), int'(duty_out), vecs[i].exp_duty);
            chk($sformatf("vec%0d_at", i), int'(at_target), int'(vecs[i].exp_at));
            chk($sformatf("vec%0d_ramp", i), int'(ramping), int'(vecs[i].exp_ramp));
        end
        period_start = 1'b0;

        // Ramp down with clamp at the target
        preset(250);
        chk("preset_250", int'(duty_out), 250);
        step_size = 4'd15;
        ramp_div = 16'd0;
        target_duty = 8'd5;
        e = 250;
        for (int k = 0; k < 20 && e != 5; k++) begin
            e = (e - 5 <= 15) ? 5 : e - 15;
            boundary(4);
            chk("down_step", int'(duty_out), e);
        end
        cyc();
        chk("down_done_at", int'(at_target), 1);
        chk("down_done_ramp", int'(ramping), 0);

        // Saturation at 255, then step_size 0 behaving as 1
        preset(250);
        target_duty = 8'd255;
        boundary(4);
        chk("sat_255", int'(duty_out), 255);
        step_size = 4'd0;
        target_duty = 8'd252;
        for (int k = 1; k <= 3; k++) begin
            boundary(4);
            chk("step0", int'(duty_out), 255 - k);
        end

        // Several prescaler ticks per period collapse into a single step
        target_duty = 8'd0;
        do_reset();
        ramp_div = 16'd9;
        step_size = 4'd1;
        target_duty = 8'd4;
        for (int k = 1; k <= 4; k++) begin
            boundary(40);
            chk("collapse", int'(duty_out), k);
        end

        // Reversal mid-ramp, then bypass
        target_duty = 8'd0;
        do_reset();
        ramp_div = 16'd0;
        step_size = 4'd1;
        target_duty = 8'd100;
        for (int k = 0; k < 30; k++) boundary(4);
        chk("rev_up_30", int'(duty_out), 30);
        chk("rev_up_ramp", int'(ramping), 1);
        target_duty = 8'd20;
        for (int k = 1; k <= 10; k++) begin
            boundary(4);
            chk("rev_down", int'(duty_out), 30 - k);
        end
        cyc();
        chk("rev_idle", int'(ramping), 0);
        ramp_en = 1'b0;
        target_duty = 8'd200;
        cyc();
        cyc();
        chk("bypass_wait", int'(duty_out), 20);
        period_start = 1'b1;
        cyc();
        period_start = 1'b0;
        chk("bypass_load", int'(duty_out), 200);
        chk("bypass_at", int'(at_target), 1);
        chk("bypass_ramp", int'(ramping), 0);
        ramp_en = 1'b1;

        // Asynchronous reset in the middle of a ramp
        target_duty = 8'd0;
        do_reset();
        step_size = 4'd15;
        target_duty = 8'd200;
        for (int k = 0; k < 3; k++) boundary(4);
        chk("async_pre", int'(duty_out), 45);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_duty", int'(duty_out), 0);
        chk("async_at", int'(at_target), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic against the reference model
        for (int b = 0; b < 4; b++) begin
            target_duty = 8'($urandom_range(0, 255));
            do_reset();
            ramp_div  = 16'($urandom_range(0, 4));
            step_size = 4'($urandom_range(0, 15));
            ramp_en   = 1'b1;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 15) == 0) target_duty = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 39) == 0) ramp_en = ~ramp_en;
                if ($urandom_range(0, 49) == 0) step_size = 4'($urandom_range(0, 15));
                period_start = ($urandom_range(0, 4) == 0);
                model_step();
                cyc();
                chk("rand_duty", int'(duty_out), m_duty);
                chk("rand_at", int'(at_target), int'(!m_active));
                chk("rand_ramp", int'(ramping), int'(m_active));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
